// File: rtl/arbitro_salida.sv
// -----------------------------------------------------------------------------
// arbitro_salida
//
// Round-robin pop arbiter for the four transaction-layer output FIFOs. It
// issues at most one pop per cycle, rotating between FIFOs with a burst limit.
// It forwards each popped word downstream as a registered stream that is
// tagged with the index of its source FIFO.
//
// Ports
//   clk                    : sole clock, rising edge
//   rst_l                  : synchronous reset, active low
//   data_out_FIFO_0..3     : FIFO read data, valid the cycle after its pop
//   empty_FIFO_0..3        : registered FIFO empty flags
//   pause                  : downstream back-pressure, blocks new pops
//   pop_0..3               : one-hot (or zero) read strobes to the FIFOs
//   data_out               : registered word forwarded downstream
//   valid_out              : qualifier for data_out / src_idx
//   src_idx                : FIFO index that data_out came from
//   idle                   : high while the arbiter sits in IDLE
// -----------------------------------------------------------------------------
module arbitro_salida #(
    parameter int DATA_W = 10,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [DATA_W-1:0] data_out_FIFO_0,
    input  logic [DATA_W-1:0] data_out_FIFO_1,
    input  logic [DATA_W-1:0] data_out_FIFO_2,
    input  logic [DATA_W-1:0] data_out_FIFO_3,
    input  logic              empty_FIFO_0,
    input  logic              empty_FIFO_1,
    input  logic              empty_FIFO_2,
    input  logic              empty_FIFO_3,
    input  logic              pause,
    output logic              pop_0,
    output logic              pop_1,
    output logic              pop_2,
    output logic              pop_3,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        src_idx,
    output logic              idle
);

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [3:0] BURST_LIM = 4'(BURST);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        rr;
    logic [1:0]        rr_nxt;
    logic [3:0]        bcnt;
    logic [3:0]        bcnt_nxt;
    logic [3:0]        empty_vec;
    logic [3:0]        pop_vec;
    logic              grant_vld;
    logic [1:0]        grant_idx;
    logic [1:0]        cand;
    logic              inflight;
    logic [1:0]        inflight_idx;
    logic [DATA_W-1:0] fifo_data [4];

    assign empty_vec = {empty_FIFO_3, empty_FIFO_2, empty_FIFO_1, empty_FIFO_0};

    assign fifo_data[0] = data_out_FIFO_0;
    assign fifo_data[1] = data_out_FIFO_1;
    assign fifo_data[2] = data_out_FIFO_2;
    assign fifo_data[3] = data_out_FIFO_3;

    // Modulo-4 step around the ring; the 2-bit sum wraps 3 -> 0 on its own.
    function automatic logic [1:0] ring_step(input logic [1:0] base, input int off);
        return base + 2'(off);
    endfunction

    // -------------------------------------------------------------------------
    // Grant selection (combinational, gated by state, pause and live empties)
    // -------------------------------------------------------------------------
    // The scan ends at offset 4, which is rr itself: when only the current
    // FIFO has data and its burst is used up, it is re-granted with a fresh
    // burst instead of stalling a single active source.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr;
        cand      = rr;
        rr_nxt    = rr;
        bcnt_nxt  = bcnt;
        if (state == ST_ACTIVE && !pause) begin
            if (!empty_vec[rr] && bcnt < BURST_LIM) begin
                grant_vld = 1'b1;
                grant_idx = rr;
                bcnt_nxt  = bcnt + 4'd1;
            end else begin
                for (int i = 1; i <= 4; i++) begin
                    cand = ring_step(rr, i);
                    if (!grant_vld && !empty_vec[cand]) begin
                        grant_vld = 1'b1;
                        grant_idx = cand;
                    end
                end
                if (grant_vld) begin
                    rr_nxt   = grant_idx;
                    bcnt_nxt = 4'd1;
                end
            end
        end
    end

    assign pop_vec = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
    assign pop_0   = pop_vec[0];
    assign pop_1   = pop_vec[1];
    assign pop_2   = pop_vec[2];
    assign pop_3   = pop_vec[3];

    // -------------------------------------------------------------------------
    // State machine next state
    // -------------------------------------------------------------------------
    // Leaving ACTIVE waits for the pipeline to drain so the last word is
    // delivered before idle is reported.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_IDLE;
            ST_IDLE:   if (!(&empty_vec)) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if ((&empty_vec) && !inflight) state_nxt = ST_IDLE;
            default:   state_nxt = ST_RESET;
        endcase
    end

    assign idle = (state == ST_IDLE);

    // -------------------------------------------------------------------------
    // Control registers and pop tracking (stage 1: pop issued -> inflight)
    // -------------------------------------------------------------------------
    // A reset drops the in-flight marker, so any word popped just before
    // reset is discarded rather than emitted.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state        <= ST_RESET;
            rr           <= 2'd0;
            bcnt         <= 4'd0;
            inflight     <= 1'b0;
            inflight_idx <= 2'd0;
        end else begin
            state    <= state_nxt;
            rr       <= rr_nxt;
            bcnt     <= bcnt_nxt;
            inflight <= grant_vld;
            if (grant_vld) begin
                inflight_idx <= grant_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output capture (stage 2: FIFO read data -> data_out)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            src_idx   <= 2'd0;
        end else begin
            valid_out <= inflight;
            if (inflight) begin
                data_out <= fifo_data[inflight_idx];
                src_idx  <= inflight_idx;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_salida.sv
// -----------------------------------------------------------------------------
// tb_arbitro_salida
//
// Directed bench for arbitro_salida. It uses behavioural registered-read FIFOs
// that feed the DUT, and a negedge monitor that logs pops and output words
// with their cycle numbers. Scenario tasks compare these logs with sequences
// worked out by hand.
// -----------------------------------------------------------------------------
module tb_arbitro_salida;

    localparam int DATA_W = 10;
    localparam int BURST  = 4;

    logic              clk   = 1'b0;
    logic              rst_l = 1'b0;
    logic              pause = 1'b0;
    logic [3:0]        empty = 4'hF;
    logic [3:0]        pops;
    logic [DATA_W-1:0] dq [4] = '{default: '0};
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [1:0]        src_idx;
    logic              idle;

    always #5 clk = ~clk;

    arbitro_salida #(.DATA_W(DATA_W), .BURST(BURST)) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .data_out_FIFO_0 (dq[0]),
        .data_out_FIFO_1 (dq[1]),
        .data_out_FIFO_2 (dq[2]),
        .data_out_FIFO_3 (dq[3]),
        .empty_FIFO_0    (empty[0]),
        .empty_FIFO_1    (empty[1]),
        .empty_FIFO_2    (empty[2]),
        .empty_FIFO_3    (empty[3]),
        .pause           (pause),
        .pop_0           (pops[0]),
        .pop_1           (pops[1]),
        .pop_2           (pops[2]),
        .pop_3           (pops[3]),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .src_idx         (src_idx),
        .idle            (idle)
    );

    // FIFO models: absolute pointers, registered read data and empty flags.
    logic [DATA_W-1:0] mem [4][256];
    int wr [4] = '{default: 0};
    int rd [4] = '{default: 0};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (pops[k] === 1'b1 && rd[k] != wr[k]) begin
                dq[k]    <= mem[k][rd[k]];
                rd[k]    <= rd[k] + 1;
                empty[k] <= ((rd[k] + 1) == wr[k]);
            end else begin
                empty[k] <= (rd[k] == wr[k]);
            end
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct { int cyc; int idx; } pop_t;
    typedef struct { int cyc; int src; int dat; } out_t;
    pop_t pop_q[$];
    out_t out_q[$];
    int   multi_pop = 0;
    int   empty_pop = 0;

    always @(negedge clk) begin
        if ($countones(pops) > 1) multi_pop++;
        if ((pops & empty) != 4'b0000) empty_pop++;
        for (int k = 0; k < 4; k++) begin
            if (pops[k] === 1'b1) pop_q.push_back('{cyc_cnt, k});
        end
        if (valid_out === 1'b1) out_q.push_back('{cyc_cnt, int'(src_idx), int'(data_out)});
    end

    int errors = 0;
    int checks = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input int base, input int n);
        for (int i = 0; i < n; i++) mem[k][wr[k] + i] = DATA_W'(base + i);
        wr[k] = wr[k] + n;
    endtask

    task automatic clear_logs;
        pop_q.delete();
        out_q.delete();
    endtask

    task automatic wait_idle(input int bound, output int ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            if (idle === 1'b1) begin
                ok = 1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic test_reset;
        int ok;
        rst_l = 1'b0;
        for (int k = 0; k < 4; k++) load(k, 'h100 + k, 1);
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checks++;
            if (pops !== 4'b0000 || valid_out !== 1'b0 || idle !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: pops=%b valid=%b idle=%b required 0000/0/0", i, pops, valid_out, idle);
            end
        end
        clear_logs();
        rst_l = 1'b1;
        cyc(1);
        checks++;
        if (idle !== 1'b1 || pops !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release_idle: idle=%b pops=%b required 1/0000", idle, pops);
        end
        cyc(1);
        checks++;
        if (idle !== 1'b0 || pops !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_pop: idle=%b pops=%b required 0/0001", idle, pops);
        end
        wait_idle(30, ok);
        checks++;
        if (ok != 1) begin
            errors++;
            $display("FAIL reset_drain_timeout: idle never returned");
        end
        checks++;
        if (out_q.size() != 4) begin
            errors++;
            $display("FAIL reset_out_count: got %0d required 4", out_q.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (out_q[j].dat != ('h100 + j) || out_q[j].src != j) begin
                    errors++;
                    $display("FAIL reset_out[%0d]: data=%0h src=%0d required %0h/%0d", j, out_q[j].dat, out_q[j].src, 'h100 + j, j);
                end
            end
        end
    endtask

    task automatic test_single_source;
        int ok;
        rst_l = 1'b0;
        load(1, 'h3A0, 6);
        cyc(2);
        clear_logs();
        rst_l = 1'b1;
        cyc(2);
        wait_idle(40, ok);
        checks++;
        if (ok != 1) begin
            errors++;
            $display("FAIL single_timeout: idle never returned");
        end
        checks++;
        if (pop_q.size() != 6 || out_q.size() != 6) begin
            errors++;
            $display("FAIL single_count: pops=%0d outs=%0d required 6/6", pop_q.size(), out_q.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (pop_q[j].idx != 1 || pop_q[j].cyc != pop_q[0].cyc + j) begin
                    errors++;
                    $display("FAIL single_pop[%0d]: idx=%0d cyc=%0d required 1/%0d", j, pop_q[j].idx, pop_q[j].cyc, pop_q[0].cyc + j);
                end
                checks++;
                if (out_q[j].dat != ('h3A0 + j) || out_q[j].src != 1 || out_q[j].cyc != pop_q[j].cyc + 2) begin
                    errors++;
                    $display("FAIL single_out[%0d]: data=%0h src=%0d cyc=%0d required %0h/1/%0d", j, out_q[j].dat, out_q[j].src, out_q[j].cyc, 'h3A0 + j, pop_q[j].cyc + 2);
                end
            end
            checks++;
            if (cyc_cnt != out_q[5].cyc + 1) begin
                errors++;
                $display("FAIL single_idle_cycle: idle at %0d required %0d", cyc_cnt, out_q[5].cyc + 1);
            end
        end
    endtask

    task automatic test_rotation;
        int ok;
        int f;
        rst_l = 1'b0;
        for (int k = 0; k < 4; k++) load(k, k * 64, 8);
        cyc(2);
        clear_logs();
        rst_l = 1'b1;
        cyc(2);
        wait_idle(100, ok);
        checks++;
        if (ok != 1) begin
            errors++;
            $display("FAIL rot_timeout: idle never returned");
        end
        checks++;
        if (pop_q.size() != 32 || out_q.size() != 32) begin
            errors++;
            $display("FAIL rot_count: pops=%0d outs=%0d required 32/32", pop_q.size(), out_q.size());
        end else begin
            for (int j = 0; j < 32; j++) begin
                f = (j / 4) % 4;
                checks++;
                if (pop_q[j].idx != f || out_q[j].src != f || out_q[j].dat != f * 64 + (j / 16) * 4 + (j % 4)) begin
                    errors++;
                    $display("FAIL rot_seq[%0d]: pop=%0d src=%0d data=%0h required %0d/%0d/%0h", j, pop_q[j].idx, out_q[j].src, out_q[j].dat, f, f, f * 64 + (j / 16) * 4 + (j % 4));
                end
            end
            checks++;
            if (out_q[31].cyc - out_q[0].cyc != 31) begin
                errors++;
                $display("FAIL rot_throughput: span=%0d required 31", out_q[31].cyc - out_q[0].cyc);
            end
        end
    endtask

    task automatic test_sparse_wrap;
        int ok;
        int exp_idx [4] = '{0, 0, 3, 3};
        int exp_dat [4] = '{'h0D0, 'h0D1, 'h3D0, 'h3D1};
        // Drain four words from FIFO3 alone: leaves rr=3 with the burst used up.
        rst_l = 1'b0;
        load(3, 'h3C0, 4);
        cyc(2);
        clear_logs();
        rst_l = 1'b1;
        cyc(2);
        wait_idle(30, ok);
        checks++;
        if (ok != 1 || pop_q.size() != 4) begin
            errors++;
            $display("FAIL sparse_setup: idle=%0d pops=%0d required 1/4", ok, pop_q.size());
        end
        clear_logs();
        load(3, 'h3D0, 2);
        load(0, 'h0D0, 2);
        cyc(3);
        wait_idle(30, ok);
        checks++;
        if (ok != 1 || pop_q.size() != 4 || out_q.size() != 4) begin
            errors++;
            $display("FAIL sparse_count: idle=%0d pops=%0d outs=%0d required 1/4/4", ok, pop_q.size(), out_q.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (pop_q[j].idx != exp_idx[j] || out_q[j].dat != exp_dat[j] || out_q[j].src != exp_idx[j]) begin
                    errors++;
                    $display("FAIL sparse_seq[%0d]: pop=%0d data=%0h src=%0d required %0d/%0h/%0d", j, pop_q[j].idx, out_q[j].dat, out_q[j].src, exp_idx[j], exp_dat[j], exp_idx[j]);
                end
            end
        end
    endtask

    task automatic test_back_pressure;
        int ok;
        int found;
        int p;
        int bad;
        int exp_idx [16] = '{2, 2, 2, 2, 3, 3, 3, 3, 2, 2, 2, 2, 3, 3, 3, 3};
        int exp_dat [16] = '{'h200, 'h201, 'h202, 'h203, 'h300, 'h301, 'h302, 'h303,
                             'h204, 'h205, 'h206, 'h207, 'h304, 'h305, 'h306, 'h307};
        rst_l = 1'b0;
        load(2, 'h200, 8);
        load(3, 'h300, 8);
        cyc(2);
        clear_logs();
        rst_l = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (pops[2] === 1'b1) begin
                found = 1;
                break;
            end
        end
        p = cyc_cnt;
        checks++;
        if (found != 1) begin
            errors++;
            $display("FAIL bp_start_timeout: no pop_2 seen");
        end
        cyc(2);
        pause = 1'b1;
        #1;
        checks++;
        if (pops !== 4'b0000) begin
            errors++;
            $display("FAIL bp_stop_same_cycle: pops=%b required 0000", pops);
        end
        cyc(5);
        pause = 1'b0;
        #1;
        checks++;
        if (pops !== 4'b0100) begin
            errors++;
            $display("FAIL bp_resume_same_cycle: pops=%b required 0100", pops);
        end
        wait_idle(60, ok);
        checks++;
        if (ok != 1) begin
            errors++;
            $display("FAIL bp_timeout: idle never returned");
        end
        bad = 0;
        foreach (pop_q[j]) if (pop_q[j].cyc >= p + 2 && pop_q[j].cyc <= p + 6) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_pop_while_paused: %0d pops required 0", bad);
        end
        checks++;
        if (pop_q.size() != 16 || out_q.size() != 16) begin
            errors++;
            $display("FAIL bp_count: pops=%0d outs=%0d required 16/16", pop_q.size(), out_q.size());
        end else begin
            checks++;
            if (pop_q[0].cyc != p || pop_q[1].cyc != p + 1 || pop_q[2].cyc != p + 7 || pop_q[3].cyc != p + 8 || pop_q[4].cyc != p + 9) begin
                errors++;
                $display("FAIL bp_pop_cycles: %0d %0d %0d %0d %0d required %0d %0d %0d %0d %0d", pop_q[0].cyc, pop_q[1].cyc, pop_q[2].cyc, pop_q[3].cyc, pop_q[4].cyc, p, p + 1, p + 7, p + 8, p + 9);
            end
            checks++;
            if (out_q[1].cyc != p + 3 || out_q[1].dat != 'h201) begin
                errors++;
                $display("FAIL bp_inflight_word: cyc=%0d data=%0h required %0d/201", out_q[1].cyc, out_q[1].dat, p + 3);
            end
            for (int j = 0; j < 16; j++) begin
                checks++;
                if (pop_q[j].idx != exp_idx[j] || out_q[j].dat != exp_dat[j] || out_q[j].src != exp_idx[j]) begin
                    errors++;
                    $display("FAIL bp_seq[%0d]: pop=%0d data=%0h src=%0d required %0d/%0h/%0d", j, pop_q[j].idx, out_q[j].dat, out_q[j].src, exp_idx[j], exp_dat[j], exp_idx[j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int ok;
        int n;
        int exp_idx [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        int exp_dat [13] = '{'h053, 'h054, 'h055, 'h056, 'h150, 'h151, 'h152, 'h153,
                             'h057, 'h154, 'h155, 'h156, 'h157};
        rst_l = 1'b0;
        load(0, 'h050, 8);
        load(1, 'h150, 8);
        cyc(2);
        rst_l = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (pops[0] === 1'b1) n++;
            if (n == 3) break;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL mid_start_timeout: saw %0d pops of FIFO0 required 3", n);
        end
        // Third pop (word 0x052) is on the strobe now; reset lands at this edge.
        rst_l = 1'b0;
        cyc(1);
        clear_logs();
        checks++;
        if (valid_out !== 1'b0 || pops !== 4'b0000 || idle !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_flush: valid=%b pops=%b idle=%b required 0/0000/0", valid_out, pops, idle);
        end
        cyc(1);
        checks++;
        if (valid_out !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL mid_reset_discard: valid=%b data=%0h required 0/0", valid_out, data_out);
        end
        rst_l = 1'b1;
        cyc(2);
        wait_idle(80, ok);
        checks++;
        if (ok != 1 || pop_q.size() != 13 || out_q.size() != 13) begin
            errors++;
            $display("FAIL mid_restart_count: idle=%0d pops=%0d outs=%0d required 1/13/13", ok, pop_q.size(), out_q.size());
        end else begin
            for (int j = 0; j < 13; j++) begin
                checks++;
                if (pop_q[j].idx != exp_idx[j] || out_q[j].dat != exp_dat[j] || out_q[j].src != exp_idx[j]) begin
                    errors++;
                    $display("FAIL mid_seq[%0d]: pop=%0d data=%0h src=%0d required %0d/%0h/%0d", j, pop_q[j].idx, out_q[j].dat, out_q[j].src, exp_idx[j], exp_dat[j], exp_idx[j]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_source();
        test_rotation();
        test_sparse_wrap();
        test_back_pressure();
        test_reset_mid();
        checks++;
        if (multi_pop != 0) begin
            errors++;
            $display("FAIL one_hot_pop: %0d cycles with several pops required 0", multi_pop);
        end
        checks++;
        if (empty_pop != 0) begin
            errors++;
            $display("FAIL pop_on_empty: %0d cycles popping an empty FIFO required 0", empty_pop);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
